// File: rtl/fft_bitrev_loader_pkg.sv
// Shared FFT parameters and helpers: default widths, bank state encoding,
// and the bit-reverse function used by the FFT front end.
package fft_bitrev_loader_pkg;

  localparam int unsigned FFT_DATA_WIDTH = 24;
  localparam int unsigned FFT_LOG2_N     = 10;
  localparam int unsigned FFT_MAX_LOG2_N = 16;

  typedef enum logic [1:0] {
    BANK_EMPTY    = 2'd0,
    BANK_FILLING  = 2'd1,
    BANK_FULL     = 2'd2,
    BANK_DRAINING = 2'd3
  } bank_state_e;

  // Reverse the low 'width' bits of x; shifting avoids variable bit indices.
  function automatic logic [FFT_MAX_LOG2_N-1:0] bitrev(
    input logic [FFT_MAX_LOG2_N-1:0] x,
    input int unsigned               width
  );
    logic [FFT_MAX_LOG2_N-1:0] r;
    logic [FFT_MAX_LOG2_N-1:0] v;
    r = '0;
    v = x;
    for (int unsigned i = 0; i < FFT_MAX_LOG2_N; i++) begin
      if (i < width) begin
        r = {r[FFT_MAX_LOG2_N-2:0], v[0]};
        v = v >> 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_dpram.sv
// Simple dual-port RAM, one write and one registered read port.
// Ports: clk; wr_en_i/wr_addr_i/wr_data_i write port;
//        rd_en_i/rd_addr_i read request, rd_data_o valid one cycle later.
module fft_dpram
  import fft_bitrev_loader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = FFT_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = FFT_LOG2_N + 1
) (
  input  logic                  clk,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_en_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic [DATA_WIDTH-1:0] rd_data_o
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
    if (rd_en_i) rd_data_o <= mem_q[rd_addr_i];
  end

endmodule

// File: rtl/fft_bitrev_loader.sv
// Ping-pong frame loader: writes real samples in bit-reversed order into one
// bank while the other bank is read out in natural order as complex words.
// Ports: clk, reset (async, active high);
//        i_sample/i_sample_valid/o_sample_ready input stream;
//        o_data {re,im=0}/o_data_valid/i_out_ready output stream,
//        o_index natural position in frame, o_frame_last on index N-1.
module fft_bitrev_loader
  import fft_bitrev_loader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = FFT_DATA_WIDTH,
  parameter int unsigned LOG2_N     = FFT_LOG2_N
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic signed [DATA_WIDTH-1:0]   i_sample,
  input  logic                           i_sample_valid,
  output logic                           o_sample_ready,
  output logic signed [2*DATA_WIDTH-1:0] o_data,
  output logic                           o_data_valid,
  input  logic                           i_out_ready,
  output logic [LOG2_N-1:0]              o_index,
  output logic                           o_frame_last
);

  bank_state_e bank_q [2];
  bank_state_e bank_d [2];
  logic                  wr_bank_q, wr_bank_d;
  logic                  rd_bank_q, rd_bank_d;
  logic [LOG2_N-1:0]     wr_cnt_q, wr_cnt_d;
  logic [LOG2_N-1:0]     rd_cnt_q, rd_cnt_d;
  logic                  ready_q, ready_d;
  logic                  wr_en_c, rd_en_c, pop_c, credit_c;
  logic [1:0]            occ_c;
  logic [LOG2_N:0]       wr_addr_c, rd_addr_c;
  logic [DATA_WIDTH-1:0] ram_rd_data;
  logic                  pipe_vld_q;
  logic [LOG2_N-1:0]     pipe_idx_q;
  logic                  head_vld_q, head_vld_d, skid_vld_q, skid_vld_d;
  logic [DATA_WIDTH-1:0] head_data_q, head_data_d, skid_data_q, skid_data_d;
  logic [LOG2_N-1:0]     head_idx_q, head_idx_d, skid_idx_q, skid_idx_d;

  assign wr_addr_c = {wr_bank_q, LOG2_N'(bitrev(FFT_MAX_LOG2_N'(wr_cnt_q), LOG2_N))};
  assign rd_addr_c = {rd_bank_q, rd_cnt_q};
  assign pop_c     = head_vld_q & i_out_ready;
  // Words already buffered or in flight from the RAM, net of this cycle's pop,
  // must leave room for the read issued now when it lands two edges later.
  assign occ_c     = 2'(head_vld_q) + 2'(skid_vld_q) + 2'(pipe_vld_q);
  assign credit_c  = occ_c <= (2'd1 + 2'(pop_c));

  fft_dpram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (LOG2_N + 1)
  ) u_ram (
    .clk       (clk),
    .wr_en_i   (wr_en_c),
    .wr_addr_i (wr_addr_c),
    .wr_data_i (i_sample),
    .rd_en_i   (rd_en_c),
    .rd_addr_i (rd_addr_c),
    .rd_data_o (ram_rd_data)
  );

  // Bank state, writer and reader registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bank_q[0]  <= BANK_EMPTY;
      bank_q[1]  <= BANK_EMPTY;
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      wr_cnt_q   <= '0;
      rd_cnt_q   <= '0;
      ready_q    <= 1'b0;
      pipe_vld_q <= 1'b0;
      pipe_idx_q <= '0;
    end else begin
      bank_q     <= bank_d;
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      ready_q    <= ready_d;
      pipe_vld_q <= rd_en_c;
      if (rd_en_c) pipe_idx_q <= rd_cnt_q;
    end
  end

  // Writer and reader touch disjoint banks, so both updates apply independently.
  always_comb begin
    bank_d    = bank_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    wr_cnt_d  = wr_cnt_q;
    rd_cnt_d  = rd_cnt_q;
    wr_en_c   = ready_q & i_sample_valid;
    rd_en_c   = 1'b0;
    if (wr_en_c) begin
      wr_cnt_d = wr_cnt_q + LOG2_N'(1);
      if (wr_cnt_q == '1) begin
        bank_d[wr_bank_q] = BANK_FULL;
        wr_bank_d         = ~wr_bank_q;
      end else begin
        bank_d[wr_bank_q] = BANK_FILLING;
      end
    end
    if ((bank_q[rd_bank_q] == BANK_FULL || bank_q[rd_bank_q] == BANK_DRAINING) && credit_c) begin
      rd_en_c  = 1'b1;
      rd_cnt_d = rd_cnt_q + LOG2_N'(1);
      if (rd_cnt_q == '1) begin
        bank_d[rd_bank_q] = BANK_EMPTY;
        rd_bank_d         = ~rd_bank_q;
      end else begin
        bank_d[rd_bank_q] = BANK_DRAINING;
      end
    end
    ready_d = (bank_d[wr_bank_d] == BANK_EMPTY) || (bank_d[wr_bank_d] == BANK_FILLING);
  end

  // Output register (head) plus one skid entry behind it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_vld_q  <= 1'b0;
      head_data_q <= '0;
      head_idx_q  <= '0;
      skid_vld_q  <= 1'b0;
      skid_data_q <= '0;
      skid_idx_q  <= '0;
    end else begin
      head_vld_q  <= head_vld_d;
      head_data_q <= head_data_d;
      head_idx_q  <= head_idx_d;
      skid_vld_q  <= skid_vld_d;
      skid_data_q <= skid_data_d;
      skid_idx_q  <= skid_idx_d;
    end
  end

  always_comb begin
    head_vld_d  = head_vld_q;
    head_data_d = head_data_q;
    head_idx_d  = head_idx_q;
    skid_vld_d  = skid_vld_q;
    skid_data_d = skid_data_q;
    skid_idx_d  = skid_idx_q;
    if (pop_c) begin
      if (skid_vld_q) begin
        head_data_d = skid_data_q;
        head_idx_d  = skid_idx_q;
        skid_vld_d  = pipe_vld_q;
        if (pipe_vld_q) begin
          skid_data_d = ram_rd_data;
          skid_idx_d  = pipe_idx_q;
        end
      end else begin
        head_vld_d = pipe_vld_q;
        if (pipe_vld_q) begin
          head_data_d = ram_rd_data;
          head_idx_d  = pipe_idx_q;
        end
      end
    end else if (pipe_vld_q) begin
      if (!head_vld_q) begin
        head_vld_d  = 1'b1;
        head_data_d = ram_rd_data;
        head_idx_d  = pipe_idx_q;
      end else begin
        skid_vld_d  = 1'b1;
        skid_data_d = ram_rd_data;
        skid_idx_d  = pipe_idx_q;
      end
    end
  end

  assign o_sample_ready = ready_q;
  assign o_data_valid   = head_vld_q;
  assign o_data         = {head_data_q, {DATA_WIDTH{1'b0}}};
  assign o_index        = head_idx_q;
  assign o_frame_last   = head_vld_q & (head_idx_q == '1);

endmodule

// File: tb/tb_fft_bitrev_loader.sv
module tb_fft_bitrev_loader;

  localparam int unsigned DW = 24;
  localparam int unsigned LG = 3;
  localparam int          N  = 8;

  logic                   clk = 1'b0;
  logic                   reset;
  logic signed [DW-1:0]   i_sample;
  logic                   i_sample_valid;
  logic                   o_sample_ready;
  logic signed [2*DW-1:0] o_data;
  logic                   o_data_valid;
  logic                   i_out_ready;
  logic [LG-1:0]          o_index;
  logic                   o_frame_last;

  fft_bitrev_loader #(.DATA_WIDTH(DW), .LOG2_N(LG)) dut (
    .clk            (clk),
    .reset          (reset),
    .i_sample       (i_sample),
    .i_sample_valid (i_sample_valid),
    .o_sample_ready (o_sample_ready),
    .o_data         (o_data),
    .o_data_valid   (o_data_valid),
    .i_out_ready    (i_out_ready),
    .o_index        (o_index),
    .o_frame_last   (o_frame_last)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [2*DW-1:0] data;
    logic [LG-1:0]   idx;
    logic            last;
  } word_t;

  word_t got_q[$];
  word_t exp_q[$];
  int    got_cyc_q[$];
  int    part_q[$];
  int    stim_q[$];
  int    first_valid_cyc;
  int    last_acc_cyc;
  int    ready_low_cycles;

  function automatic int bitrev_ref(int a);
    int r = 0;
    for (int i = 0; i < int'(LG); i++)
      if ((a >> i) % 2 == 1) r += 1 << (int'(LG) - 1 - i);
    return r;
  endfunction

  // Reference model: a completed frame yields N words, word k = sample[bitrev(k)].
  function automatic void model_accept(int s);
    part_q.push_back(s);
    if (part_q.size() == N) begin
      for (int a = 0; a < N; a++) begin
        word_t w;
        w.data = {DW'(part_q[bitrev_ref(a)]), DW'(0)};
        w.idx  = LG'(a);
        w.last = (a == N - 1);
        exp_q.push_back(w);
      end
      part_q.delete();
    end
  endfunction

  function automatic void clear_all();
    got_q.delete(); exp_q.delete(); got_cyc_q.delete(); part_q.delete(); stim_q.delete();
  endfunction

  function automatic int rand_sample();
    return int'($urandom_range(0, 16777215)) - 8388608;
  endfunction

  // Drives stim_q and collects output transfers; decisions made on the falling edge.
  task automatic stream(input int rdy_pct, input int vld_pct, input bit wait_out, input int max_cyc);
    int n = 0;
    first_valid_cyc  = -1;
    last_acc_cyc     = -1;
    ready_low_cycles = 0;
    while (n < max_cyc && (stim_q.size() > 0 || (wait_out && got_q.size() < exp_q.size()))) begin
      @(negedge clk);
      n++;
      i_out_ready = (int'($urandom_range(0, 99)) < rdy_pct);
      if (stim_q.size() > 0 && int'($urandom_range(0, 99)) < vld_pct) begin
        i_sample_valid = 1'b1;
        i_sample       = DW'(stim_q[0]);
      end else begin
        i_sample_valid = 1'b0;
      end
      if (stim_q.size() > 0 && !o_sample_ready) ready_low_cycles++;
      if (o_data_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (o_data_valid && i_out_ready) begin
        got_q.push_back({o_data, o_index, o_frame_last});
        got_cyc_q.push_back(cyc);
      end
      if (i_sample_valid && o_sample_ready) begin
        model_accept(stim_q.pop_front());
        last_acc_cyc = cyc + 1;
      end
    end
    checks++;
    if (n >= max_cyc) begin
      errors++;
      $display("FAIL stream_timeout: got %0d words, required %0d, samples left %0d",
               got_q.size(), exp_q.size(), stim_q.size());
    end
    @(negedge clk);
    i_sample_valid = 1'b0;
    i_out_ready    = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; i_sample = '0; i_sample_valid = 1'b0; i_out_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (o_data_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b required 0", o_data_valid); end
    checks++; if (o_frame_last !== 1'b0) begin errors++; $display("FAIL rst_last: got %b required 0", o_frame_last); end
    checks++; if (o_index !== '0) begin errors++; $display("FAIL rst_index: got %0d required 0", o_index); end
    checks++; if (o_data !== '0) begin errors++; $display("FAIL rst_data: got %h required 0", o_data); end
    checks++; if (o_sample_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b required 0", o_sample_ready); end
    reset = 1'b0;
    @(negedge clk);
    checks++; if (o_sample_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_rise: got %b required 1", o_sample_ready); end
  endtask

  task automatic test_single_frame();
    int lit[8] = '{0, 4, 2, 6, 1, 5, 3, 7};
    clear_all();
    for (int i = 0; i < N; i++) stim_q.push_back(i);
    stream(100, 100, 1'b1, 200);
    checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL single_count: got %0d required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL single_word%0d: got %h required %h", i, got_q[i], exp_q[i]); end
      checks++;
      if (got_q[i].data[2*DW-1:DW] !== DW'(lit[i])) begin errors++; $display("FAIL single_real%0d: got %0d required %0d", i, got_q[i].data[2*DW-1:DW], lit[i]); end
    end
    checks++;
    if (first_valid_cyc !== last_acc_cyc + 2) begin errors++; $display("FAIL single_latency: first valid edge %0d required %0d", first_valid_cyc, last_acc_cyc + 2); end
    checks++; if (o_data_valid !== 1'b0) begin errors++; $display("FAIL single_idle: valid %b required 0", o_data_valid); end
  endtask

  task automatic test_back_to_back();
    int bubbles = 0;
    clear_all();
    for (int i = 0; i < 3 * N; i++) stim_q.push_back(rand_sample());
    stream(100, 100, 1'b1, 300);
    checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL b2b_count: got %0d required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_word%0d: got %h required %h", i, got_q[i], exp_q[i]); end
    end
    for (int i = 1; i < got_cyc_q.size(); i++) if (got_cyc_q[i] != got_cyc_q[i-1] + 1) bubbles++;
    checks++; if (bubbles !== 0) begin errors++; $display("FAIL b2b_bubbles: got %0d required 0", bubbles); end
    checks++; if (ready_low_cycles !== 0) begin errors++; $display("FAIL b2b_ready_low: got %0d cycles required 0", ready_low_cycles); end
  endtask

  task automatic test_stall();
    logic [2*DW-1:0] held_data;
    logic [LG-1:0]   held_idx;
    int              changes = 0;
    clear_all();
    for (int i = 0; i < 2 * N; i++) stim_q.push_back(rand_sample());
    stream(0, 100, 1'b0, 200);
    checks++; if (o_sample_ready !== 1'b0) begin errors++; $display("FAIL stall_ready_fall: got %b required 0", o_sample_ready); end
    checks++; if (o_data_valid !== 1'b1) begin errors++; $display("FAIL stall_valid: got %b required 1", o_data_valid); end
    checks++; if (o_data !== exp_q[0].data || o_index !== exp_q[0].idx) begin errors++; $display("FAIL stall_head: got %h/%0d required %h/%0d", o_data, o_index, exp_q[0].data, exp_q[0].idx); end
    held_data = o_data;
    held_idx  = o_index;
    repeat (8) begin
      @(negedge clk);
      if (o_data !== held_data || o_index !== held_idx || o_data_valid !== 1'b1 || o_sample_ready !== 1'b0) changes++;
    end
    checks++; if (changes !== 0) begin errors++; $display("FAIL stall_hold: got %0d changes required 0", changes); end
    stream(100, 100, 1'b1, 200);
    checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL stall_count: got %0d required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL stall_word%0d: got %h required %h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (o_sample_ready !== 1'b1) begin errors++; $display("FAIL stall_ready_rise: got %b required 1", o_sample_ready); end
  endtask

  task automatic test_random_ready();
    int vals[8] = '{-8388608, 8388607, -1, 1, 0, 5, -5, 2};
    int lit[8]  = '{-8388608, 0, -1, -5, 8388607, 5, 1, 2};
    clear_all();
    for (int i = 0; i < N; i++) stim_q.push_back(vals[i]);
    for (int i = 0; i < N; i++) stim_q.push_back(rand_sample());
    stream(50, 70, 1'b1, 400);
    checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL rnd_count: got %0d required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rnd_word%0d: got %h required %h", i, got_q[i], exp_q[i]); end
    end
    for (int i = 0; i < N && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i].data[2*DW-1:DW] !== DW'(lit[i])) begin errors++; $display("FAIL rnd_signed%0d: got %h required %h", i, got_q[i].data[2*DW-1:DW], DW'(lit[i])); end
    end
  endtask

  task automatic test_reset_midframe();
    int lit[8] = '{0, 4, 2, 6, 1, 5, 3, 7};
    clear_all();
    for (int i = 0; i < N + 5; i++) stim_q.push_back(rand_sample());
    stream(0, 100, 1'b0, 200);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (o_data_valid !== 1'b0 || o_sample_ready !== 1'b0 || o_data !== '0 || o_index !== '0 || o_frame_last !== 1'b0) begin
      errors++;
      $display("FAIL midrst_async: got valid=%b ready=%b data=%h idx=%0d last=%b required all zero",
               o_data_valid, o_sample_ready, o_data, o_index, o_frame_last);
    end
    clear_all();
    repeat (2) @(negedge clk);
    checks++;
    if (o_data_valid !== 1'b0 || o_sample_ready !== 1'b0) begin errors++; $display("FAIL midrst_hold: got valid=%b ready=%b required 0/0", o_data_valid, o_sample_ready); end
    reset = 1'b0;
    for (int i = 0; i < N; i++) stim_q.push_back(i);
    stream(100, 100, 1'b1, 200);
    checks++; if (got_q.size() !== N) begin errors++; $display("FAIL midrst_count: got %0d required %0d", got_q.size(), N); end
    for (int i = 0; i < N && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i] || got_q[i].data[2*DW-1:DW] !== DW'(lit[i])) begin
        errors++; $display("FAIL midrst_word%0d: got %h required %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_stall();
    test_random_ready();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/fft_bitrev_loader.md
FFT_BITREV_LOADER -- requirements
Module: fft_bitrev_loader

Interface
REQ-001 Parameter DATA_WIDTH, default 24, bit width of each real/imaginary part.
REQ-002 Parameter LOG2_N, default 10, log2 of FFT frame length N (N = 2^LOG2_N).
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 i_sample  input  DATA_WIDTH  signed real audio sample.
REQ-006 i_sample_valid  input  1  i_sample is valid this cycle.
REQ-007 o_sample_ready  output  1  block accepts i_sample this cycle; transfer when valid and ready are both high.
REQ-008 o_data  output  2*DATA_WIDTH  signed complex word; real part in upper DATA_WIDTH bits, imaginary part in lower bits, same packing the butterfly uses.
REQ-009 o_data_valid  output  1  o_data is valid.
REQ-010 i_out_ready  input  1  downstream accepts o_data; transfer when valid and ready are both high.
REQ-011 o_index  output  LOG2_N  natural-order position (0..N-1) of o_data within the frame.
REQ-012 o_frame_last  output  1  high with the word at o_index = N-1.

Function
REQ-013 Storage is two banks (ping-pong) of N words each; each bank is either EMPTY, FILLING, FULL or DRAINING.
REQ-014 Writer: each accepted sample is stored at address bitrev(wr_cnt) of the write bank; wr_cnt counts 0..N-1.
REQ-015 When wr_cnt wraps from N-1 to 0, the write bank becomes FULL and the writer switches to the other bank.
REQ-016 o_sample_ready is high only when the current write bank is EMPTY or FILLING; it is low while the writer waits for a DRAINING/FULL bank to free.
REQ-017 Reader: the oldest FULL bank is read at sequential addresses 0..N-1; the bank becomes EMPTY on the cycle its address N-1 read issues; o_sample_ready may rise on the following cycle.
REQ-018 Output imaginary part is always 0; real part is the stored sample, unmodified (sign preserved).
REQ-019 Latency: o_data_valid for index 0 rises on the 2nd rising edge after the edge that accepted the frame's N-th sample, provided the reader is idle.
REQ-020 With i_out_ready held high, the output sustains 1 word/cycle, including back-to-back frames with no gap.
REQ-021 When o_data_valid is high and i_out_ready is low, o_data, o_index and o_frame_last hold stable; no word is lost or duplicated (1-cycle-latency RAM plus a 2-entry skid buffer).
REQ-022 Simultaneous events: a writer bank completion and a reader bank release on the same edge are both honoured independently.
REQ-023 With both banks FULL, no sample is accepted until the reader frees a bank.
REQ-024 Frame order is strictly FIFO: frames leave in the order they were filled.

Reset
REQ-025 Reset (any time, including mid-frame) asynchronously forces o_data_valid=0, o_frame_last=0, o_index=0, o_data=0, and o_sample_ready=0 while reset is asserted.
REQ-026 Reset clears both banks to EMPTY, zeroes wr_cnt and rd_cnt, and discards partial or pending frames; RAM contents are not cleared.
REQ-027 o_sample_ready is high on the first edge after reset deasserts.

Structure
REQ-028 DATA_WIDTH, LOG2_N defaults and the bit-reverse function live in the shared FFT parameter package/include used by all FFT blocks.
REQ-029 Storage is one sub-module, fft_dpram: simple dual-port RAM of 2N x DATA_WIDTH, one write port, one read port, registered read (1-cycle latency). The bank select is the address MSB.

Verification (LOG2_N=3, DATA_WIDTH=24)
REQ-030 Feed samples 0..7 continuously, i_out_ready=1 -> o_data real = 0,4,2,6,1,5,3,7, imaginary 0, o_index 0..7, o_frame_last on the 8th word, first valid 2 cycles after the 8th accept.
REQ-031 Feed 24 samples back-to-back, downstream always ready -> three frames out in order, no bubble between frames, o_sample_ready never low.
REQ-032 Hold i_out_ready=0 while feeding 16 samples -> o_sample_ready falls after the 16th accept and the first output word holds stable; release i_out_ready -> all 16 words emerge correct, ready re-rises after frame 1 drains.
REQ-033 Randomly toggle i_out_ready during a frame of values -8388608, 8388607, -1, 1, 0, 5, -5, 2 -> the bit-reversed sequence is exact with sign preserved and no word is lost or repeated.
REQ-034 Assert reset after 5 samples of a frame, then feed samples 0..7 -> only the second frame appears (0,4,2,6,1,5,3,7); outputs are zero/low during reset.
